// File: rtl/axi_mem_slave_responder_if.sv
// AXI4 slave-port bundle for axi_mem_slave_responder: AW/W/B and AR/R channels.
interface axi_mem_slave_responder_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;

  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [AXI_ID_WIDTH-1:0]   arid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;

  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_slave_responder.sv
// AXI4 memory target with word-addressed RAM and OKAY/SLVERR/DECERR responses.
// Macros: AXI_SLV_BACKPRESSURE_EN (ready throttling), AXI_SLV_ASSERT (wlast check).
//
// state  | meaning
// W_IDLE | awready high, waiting for a write burst
// W_DATA | wready high, storing beats until count == awlen
// W_RESP | bvalid held until bready
// R_IDLE | arready high, waiting for a read burst
// R_DATA | rvalid high, one beat per rready until count == arlen
module axi_mem_slave_responder #(
  parameter int                        AXI_ADDR_WIDTH  = 64,
  parameter int                        AXI_DATA_WIDTH  = 64,
  parameter int                        AXI_ID_WIDTH    = 8,
  parameter int                        AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
  parameter int                        MEM_DEPTH_WORDS = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE_ADDR   = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  axi_mem_slave_responder_if.slave s_axi
);
  localparam int ADDR_LSB = $clog2(AXI_STRB_WIDTH);
  localparam int MEM_AW   = $clog2(MEM_DEPTH_WORDS);
  localparam logic [AXI_ADDR_WIDTH:0] MEM_LIMIT =
    {1'b0, MEM_BASE_ADDR} + (AXI_ADDR_WIDTH+1)'(MEM_DEPTH_WORDS * AXI_STRB_WIDTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Out-of-window addresses take precedence over malformed bursts.
  function automatic logic [1:0] classify(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                          input logic [1:0] burst,
                                          input logic [2:0] size);
    if (addr < MEM_BASE_ADDR || {1'b0, addr} >= MEM_LIMIT) return RESP_DECERR;
    else if (burst[1] || size != 3'(ADDR_LSB))             return RESP_SLVERR;
    else                                                   return RESP_OKAY;
  endfunction

  function automatic logic [MEM_AW-1:0] word_of(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - MEM_BASE_ADDR;
    return off[ADDR_LSB +: MEM_AW];
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic rdy_gate;
`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [3:0] bp_cnt;
  logic       unused_bp;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) bp_cnt <= '0;
    else         bp_cnt <= bp_cnt + 4'd1;
  end
  assign rdy_gate  = rst_ni && (bp_cnt[1:0] == 2'b00);
  assign unused_bp = ^bp_cnt[3:2];
`else
  assign rdy_gate = rst_ni;
`endif

  // ---------------- write channel ----------------
  w_state_t                w_state, w_next;
  logic [AXI_ID_WIDTH-1:0] w_id;
  logic [MEM_AW-1:0]       w_word;
  logic [7:0]              w_len, w_cnt;
  logic                    w_fixed;
  logic [1:0]              w_resp;
  logic                    aw_rdy, w_rdy, aw_hs, w_hs;

  always_comb begin
    w_next = w_state;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_rdy = rdy_gate;
        if (s_axi.awvalid && aw_rdy) w_next = W_DATA;
      end
      W_DATA: begin
        w_rdy = rdy_gate;
        if (s_axi.wvalid && w_rdy && w_cnt == w_len) w_next = W_RESP;
      end
      W_RESP: if (s_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs = s_axi.awvalid && aw_rdy;
  assign w_hs  = s_axi.wvalid && w_rdy;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_word  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_id    <= s_axi.awid;
        w_word  <= word_of(s_axi.awaddr);
        w_len   <= s_axi.awlen;
        w_cnt   <= '0;
        w_fixed <= (s_axi.awburst == 2'b00);
        w_resp  <= classify(s_axi.awaddr, s_axi.awburst, s_axi.awsize);
      end else if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        if (!w_fixed) w_word <= w_word + MEM_AW'(1);
      end
    end
  end

  // RAM has no reset; erroneous bursts consume beats without storing them.
  always_ff @(posedge clk_i) begin
    if (w_hs && w_resp == RESP_OKAY) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (s_axi.wstrb[b]) mem[w_word][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bid     = w_id;
  assign s_axi.bresp   = w_resp;

  // ---------------- read channel ----------------
  r_state_t                  r_state, r_next;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [MEM_AW-1:0]         r_word, fetch_word;
  logic [7:0]                r_len, r_cnt;
  logic                      r_fixed;
  logic [1:0]                r_resp, ar_class, fetch_resp;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic                      ar_rdy, ar_hs, r_hs, r_last;

  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_rdy = rdy_gate;
        if (s_axi.arvalid && ar_rdy) r_next = R_DATA;
      end
      R_DATA: if (s_axi.rready && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs      = s_axi.arvalid && ar_rdy;
  assign r_last     = (r_state == R_DATA) && (r_cnt == r_len);
  assign r_hs       = (r_state == R_DATA) && s_axi.rready;
  assign ar_class   = classify(s_axi.araddr, s_axi.arburst, s_axi.arsize);
  assign fetch_resp = ar_hs ? ar_class : r_resp;
  assign fetch_word = ar_hs   ? word_of(s_axi.araddr) :
                      r_fixed ? r_word : r_word + MEM_AW'(1);

  // Fetch is registered, so a same-cycle write to the fetched word is seen next fetch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_word  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_resp  <= RESP_OKAY;
      r_data  <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_id    <= s_axi.arid;
        r_len   <= s_axi.arlen;
        r_cnt   <= '0;
        r_fixed <= (s_axi.arburst == 2'b00);
        r_resp  <= ar_class;
      end else if (r_hs && !r_last) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (ar_hs || (r_hs && !r_last)) begin
        r_word <= fetch_word;
        r_data <= (fetch_resp == RESP_OKAY) ? mem[fetch_word] : '0;
      end
    end
  end

  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = (r_state == R_DATA);
  assign s_axi.rid     = r_id;
  assign s_axi.rdata   = r_data;
  assign s_axi.rresp   = r_resp;
  assign s_axi.rlast   = r_last;

`ifdef AXI_SLV_ASSERT
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_hs) assert (s_axi.wlast == (w_cnt == w_len));
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.wlast};
endmodule

// File: tb/tb_axi_mem_slave_responder.sv
// Directed bench for axi_mem_slave_responder; drives and samples on the falling edge.
module tb_axi_mem_slave_responder;
  localparam int AW = 64, DW = 64, IW = 8;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_slave_responder_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) axi ();

  axi_mem_slave_responder #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .MEM_DEPTH_WORDS(1024), .MEM_BASE_ADDR(64'h0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .s_axi (axi)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] wd   [16];
  logic [7:0]  ws   [16];
  logic [63:0] rexp [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int t = 0;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    while (!axi.awready && t < TMO) begin @(negedge clk); t++; end
    check("aw_accept", axi.awready, 1);
    @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = (i == len); axi.wvalid = 1'b1;
      while (!axi.wready && t < TMO) begin @(negedge clk); t++; end
      check("w_accept", axi.wready, 1);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [1:0] exp_resp);
    int t = 0;
    send_aw(id, addr, len, burst, size);
    send_w(int'(len) + 1, int'(len));
    axi.bready = 1'b1;
    while (!axi.bvalid && t < TMO) begin @(negedge clk); t++; end
    check("bvalid", axi.bvalid, 1);
    check("bresp", axi.bresp, exp_resp);
    check("bid", axi.bid, id);
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] exp_resp,
                            input int stall_beat, input int stall_cyc);
    int t = 0;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd3; axi.arburst = burst;
    axi.arvalid = 1'b1;
    while (!axi.arready && t < TMO) begin @(negedge clk); t++; end
    check("ar_accept", axi.arready, 1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!axi.rvalid && t < TMO) begin @(negedge clk); t++; end
      check("rvalid", axi.rvalid, 1);
      check("rdata", axi.rdata, rexp[i]);
      check("rresp", axi.rresp, exp_resp);
      check("rid", axi.rid, id);
      check("rlast", axi.rlast, (i == int'(len)));
      if (i == stall_beat) begin
        axi.rready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          check("stall_rvalid", axi.rvalid, 1);
          check("stall_rdata", axi.rdata, rexp[i]);
          check("stall_rid", axi.rid, id);
          check("stall_rlast", axi.rlast, (i == int'(len)));
        end
        axi.rready = 1'b1;
      end
      @(negedge clk);
    end
    axi.rready = 1'b0;
    check("r_idle", axi.rvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ready_cnt;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd3; axi.awburst = 2'b01;
    axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd3; axi.arburst = 2'b01;
    axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_awready", axi.awready, 0);
    check("rst_wready", axi.wready, 0);
    check("rst_arready", axi.arready, 0);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_bresp", axi.bresp, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_rlast", axi.rlast, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic INCR write/read
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    write_burst(8'h01, 64'h0, 8'd3, 2'b01, 3'd3, 2'd0);
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    read_burst(8'h02, 64'h0, 8'd3, 2'b01, 2'd0, -1, 0);

    // byte strobes on word 5
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    write_burst(8'h03, 64'h28, 8'd0, 2'b01, 3'd3, 2'd0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    write_burst(8'h04, 64'h28, 8'd0, 2'b01, 3'd3, 2'd0);
    rexp[0] = 64'hFFFF_FFFF_0000_0000;
    read_burst(8'h05, 64'h28, 8'd0, 2'b01, 2'd0, -1, 0);

    // wrong size: SLVERR, nothing stored
    wd[0] = 64'h0; ws[0] = 8'hFF;
    write_burst(8'h06, 64'h28, 8'd0, 2'b01, 3'd2, 2'd2);
    read_burst(8'h07, 64'h28, 8'd0, 2'b01, 2'd0, -1, 0);

    // INCR wraps from the last word to word 0
    wd[0] = 64'hA0A0; wd[1] = 64'hB0B0; ws[0] = 8'hFF; ws[1] = 8'hFF;
    write_burst(8'h08, 64'd8184, 8'd1, 2'b01, 3'd3, 2'd0);
    rexp[0] = 64'hA0A0; rexp[1] = 64'hB0B0;
    read_burst(8'h09, 64'd8184, 8'd1, 2'b01, 2'd0, -1, 0);
    rexp[0] = 64'hB0B0;
    read_burst(8'h0A, 64'h0, 8'd0, 2'b01, 2'd0, -1, 0);

    // out-of-window write: DECERR, word 0 untouched
    wd[0] = 64'hDEAD; ws[0] = 8'hFF;
    write_burst(8'h0B, 64'h10000, 8'd0, 2'b01, 3'd3, 2'd3);
    read_burst(8'h0C, 64'h0, 8'd0, 2'b01, 2'd0, -1, 0);

    // out-of-window read and WRAP read return zero data
    rexp[0] = 64'h0; rexp[1] = 64'h0; rexp[2] = 64'h0; rexp[3] = 64'h0;
    read_burst(8'h0D, 64'h10000, 8'd2, 2'b01, 2'd3, -1, 0);
    read_burst(8'h0E, 64'h0, 8'd3, 2'b10, 2'd2, -1, 0);

    // FIXED write keeps the last beat, neighbour word unchanged
    wd[0] = 64'h99; ws[0] = 8'hFF;
    write_burst(8'h0F, 64'h48, 8'd0, 2'b01, 3'd3, 2'd0);
    wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'd3; wd[3] = 64'd4;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    write_burst(8'h10, 64'h40, 8'd3, 2'b00, 3'd3, 2'd0);
    rexp[0] = 64'd4; rexp[1] = 64'h99;
    read_burst(8'h11, 64'h40, 8'd1, 2'b01, 2'd0, -1, 0);

    // rready stall mid-burst
    rexp[0] = 64'hB0B0; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    read_burst(8'h12, 64'h0, 8'd3, 2'b01, 2'd0, 1, 5);

    // reset during W_DATA: committed beat stays, no B
    send_aw(8'h13, 64'h80, 8'd3, 2'b01, 3'd3);
    wd[0] = 64'h5A; ws[0] = 8'hFF;
    send_w(1, 3);
    axi.bready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wready", axi.wready, 0);
    check("midrst_bvalid", axi.bvalid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_bvalid", axi.bvalid, 0);
    end
    axi.bready = 1'b0;
    wd[0] = 64'h77; ws[0] = 8'hFF;
    write_burst(8'h14, 64'h60, 8'd0, 2'b01, 3'd3, 2'd0);
    rexp[0] = 64'h77;
    read_burst(8'h15, 64'h60, 8'd0, 2'b01, 2'd0, -1, 0);
    rexp[0] = 64'h5A;
    read_burst(8'h16, 64'h80, 8'd0, 2'b01, 2'd0, -1, 0);

    // ready duty cycle while idle
    ready_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (axi.awready) ready_cnt++;
      @(negedge clk);
    end
`ifdef AXI_SLV_BACKPRESSURE_EN
    check("awready_duty", ready_cnt, 4);
`else
    check("awready_duty", ready_cnt, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
